// File: rtl/biphase_link_ctrl.sv
// biphase_link_ctrl: link hunt, async-serial framing and loss-of-link timeout behind biphase_to_nrz.
// Define GLITCH_LIMIT_EN to abort a frame once decoder glitches exceed GLITCH_LIMIT.
module biphase_link_ctrl #(
  parameter int IDLE_ONES    = 10,
  parameter int TIMEOUT      = 2000,
  parameter int GLITCH_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       framing_error_in,
  input  logic       glitch_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       link_up,
  output logic       stop_error,
  output logic       overrun,
  output logic       link_lost,
  output logic [7:0] err_count,
  input  logic       err_clear
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int OW = $clog2(IDLE_ONES + 1);
  typedef enum logic [1:0] {HUNT, IDLE, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [TW-1:0] to_q, to_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d, byte_data_q, byte_data_d, err_q, err_d;
  logic          byte_valid_q, byte_valid_d, stop_error_q, stop_error_d;
  logic          overrun_q, overrun_d, link_lost_q, link_lost_d;
  logic          fe, tmo, err_inc;
`ifdef GLITCH_LIMIT_EN
  logic       in_frame;
  logic [7:0] g_q, g_d;
  assign in_frame = (state_q == DATA) || (state_q == STOP);
  assign g_d      = in_frame ? g_q + 8'(glitch_in) : '0;
  assign fe       = framing_error_in | (in_frame & glitch_in & (g_q == 8'(GLITCH_LIMIT)));
  always_ff @(posedge clk or posedge rst)
    if (rst) g_q <= '0;
    else g_q <= g_d;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_in;
  assign fe            = framing_error_in;
`endif
  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q & ~byte_ready;
    stop_error_d = 1'b0;
    overrun_d    = 1'b0;
    link_lost_d  = 1'b0;
    err_inc      = 1'b0;
    tmo          = !bit_valid && (to_q == TW'(TIMEOUT - 1));
    to_d         = bit_valid ? '0 : (to_q == TW'(TIMEOUT) ? to_q : to_q + 1'b1);
    if (fe) begin
      err_inc = 1'b1;
      state_d = HUNT;
      ones_d  = '0;
    end else if (bit_valid) begin
      case (state_q)
        HUNT: begin
          ones_d = bit_data ? ones_q + 1'b1 : '0;
          if (bit_data && ones_q == OW'(IDLE_ONES - 1)) begin
            state_d = IDLE;
            ones_d  = '0;
          end
        end
        IDLE: begin
          state_d = bit_data ? IDLE : DATA;
          idx_d   = '0;
        end
        DATA: begin
          sh_d[idx_q] = bit_data;
          idx_d       = idx_q + 1'b1;
          state_d     = (idx_q == 3'd7) ? STOP : DATA;
        end
        STOP: begin
          // a held byte that is not being accepted this cycle wins over the new one
          if (bit_data && byte_valid_q && !byte_ready) overrun_d = 1'b1;
          else if (bit_data) begin
            byte_data_d  = sh_q;
            byte_valid_d = 1'b1;
          end
          stop_error_d = !bit_data;
          err_inc      = !bit_data;
          state_d      = bit_data ? IDLE : HUNT;
        end
      endcase
    end else if (tmo) begin
      ones_d      = '0;
      link_lost_d = state_q != HUNT;
      state_d     = HUNT;
    end
    err_d = err_clear ? '0 : (err_inc && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= HUNT;
      ones_q       <= '0;
      to_q         <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      stop_error_q <= 1'b0;
      overrun_q    <= 1'b0;
      link_lost_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      to_q         <= to_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      stop_error_q <= stop_error_d;
      overrun_q    <= overrun_d;
      link_lost_q  <= link_lost_d;
      err_q        <= err_d;
    end
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign link_up    = state_q != HUNT;
  assign stop_error = stop_error_q;
  assign overrun    = overrun_q;
  assign link_lost  = link_lost_q;
  assign err_count  = err_q;
endmodule

// File: tb/tb_biphase_link_ctrl.sv
// tb_biphase_link_ctrl: random and directed stimulus against a frame-position reference model.
module tb_biphase_link_ctrl;
  localparam int IDLE_ONES = 10, TIMEOUT = 2000, GLITCH_LIMIT = 4;
  logic clk = 0, rst = 1, bit_valid = 0, bit_data = 0, framing_error_in = 0;
  logic glitch_in = 0, byte_ready = 0, err_clear = 0;
  logic [7:0] byte_data, err_count;
  logic byte_valid, link_up, stop_error, overrun, link_lost;
  int checks = 0, failures = 0, ovr_seen = 0, lost_seen = 0;
  // phase: -1 hunting, 0 idle, 1..8 awaiting data bit phase-1, 9 awaiting stop
  int phase = -1, ones = 0, quiet = 0, gcnt = 0, m_byte = 0, m_err = 0;
  bit q_bits[$];
  bit m_valid = 0, m_stop = 0, m_ovr = 0, m_lost = 0, rnd = 0;
  always #5 clk = ~clk;
  biphase_link_ctrl #(.IDLE_ONES(IDLE_ONES), .TIMEOUT(TIMEOUT), .GLITCH_LIMIT(GLITCH_LIMIT)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_data(bit_data),
    .framing_error_in(framing_error_in), .glitch_in(glitch_in), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .link_up(link_up),
    .stop_error(stop_error), .overrun(overrun), .link_lost(link_lost),
    .err_count(err_count), .err_clear(err_clear));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(bit v, bit d, bit fe, bit gl, bit rdy, bit clr);
    bit inc = 0;
    bit old_v = m_valid;
    int b = 0;
    m_stop = 0; m_ovr = 0; m_lost = 0;
    m_valid = old_v && !rdy;
`ifdef GLITCH_LIMIT_EN
    if (phase >= 1) gcnt += gl; else gcnt = 0;
    fe = fe || (phase >= 1 && gcnt > GLITCH_LIMIT);
`endif
    if (fe) begin
      inc = 1; phase = -1; ones = 0; q_bits.delete();
    end else if (v) begin
      if (phase < 0) begin
        ones = d ? ones + 1 : 0;
        if (ones == IDLE_ONES) begin phase = 0; ones = 0; end
      end else if (phase == 0) begin
        if (!d) phase = 1;
        q_bits.delete();
      end else if (phase <= 8) begin
        q_bits.push_back(d); phase++;
      end else if (d) begin
        foreach (q_bits[i]) b += int'(q_bits[i]) << i;
        if (old_v && !rdy) m_ovr = 1;
        else begin m_byte = b; m_valid = 1; end
        phase = 0;
      end else begin
        m_stop = 1; inc = 1; phase = -1;
      end
    end else if (quiet + 1 == TIMEOUT) begin
      m_lost = phase >= 0; phase = -1; ones = 0;
    end
    quiet = v ? 0 : (quiet < TIMEOUT ? quiet + 1 : quiet);
    m_err = clr ? 0 : (inc && m_err < 255) ? m_err + 1 : m_err;
  endtask
  task automatic step(bit v, bit d, bit fe, bit gl, bit clr);
    if (rnd) begin
      byte_ready = 1'($urandom_range(0, 1));
      gl  = $urandom_range(0, 7) == 0;
      clr = $urandom_range(0, 299) == 0;
    end
    bit_valid = v; bit_data = d; framing_error_in = fe; glitch_in = gl; err_clear = clr;
    model(v, d, fe, gl, byte_ready, clr);
    @(posedge clk); #1;
    chk("link_up", link_up, phase >= 0);
    chk("byte_valid", byte_valid, m_valid);
    chk("byte_data", byte_data, m_byte);
    chk("stop_error", stop_error, m_stop);
    chk("overrun", overrun, m_ovr);
    chk("link_lost", link_lost, m_lost);
    chk("err_count", err_count, m_err);
    ovr_seen += overrun;
    lost_seen += link_lost;
  endtask
  task automatic send_bit(bit d);
    repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
    step(1, d, 0, 0, 0);
  endtask
  task automatic send_frame(logic [7:0] b, bit s);
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(s);
  endtask
  initial begin
    @(posedge clk); #1;
    chk("rst_link_up", link_up, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_pulses", {stop_error, overrun, link_lost}, 0);
    rst = 0;
    repeat (9) send_bit(1);
    send_bit(0);
    repeat (9) send_bit(1);
    chk("no_link_after_break", link_up, 0);
    send_bit(1);
    chk("link_after_10_ones", link_up, 1);
    byte_ready = 1;
    send_frame(8'h4A, 1);
    chk("byte_4a_valid", byte_valid, 1);
    chk("byte_4a_data", byte_data, 8'h4A);
    chk("byte_4a_err", err_count, 0);
    step(0, 0, 0, 0, 0);
    chk("byte_4a_drained", byte_valid, 0);
    byte_ready = 0;
    send_frame(8'h55, 1);
    ovr_seen = 0;
    send_frame(8'hA3, 1);
    chk("overrun_once", ovr_seen, 1);
    chk("overrun_held", byte_data, 8'h55);
    byte_ready = 1;
    step(0, 0, 0, 0, 0);
    send_frame(8'h3C, 0);
    chk("stop_err_pulse", stop_error, 1);
    chk("stop_err_count", err_count, 1);
    chk("stop_err_link", link_up, 0);
    chk("stop_err_nobyte", byte_valid, 0);
    repeat (10) send_bit(1);
    send_bit(0); send_bit(1); send_bit(0);
    step(1, 1, 1, 0, 0);
    chk("fe_count", err_count, 2);
    chk("fe_link", link_up, 0);
    repeat (254) step(0, 0, 1, 0, 0);
    chk("err_saturate", err_count, 255);
    step(0, 0, 1, 0, 1);
    chk("err_clear_wins", err_count, 0);
    repeat (10) send_bit(1);
    lost_seen = 0;
    repeat (TIMEOUT - 1) step(0, 0, 0, 0, 0);
    chk("pre_timeout_link", link_up, 1);
    step(0, 0, 0, 0, 0);
    chk("timeout_pulse", link_lost, 1);
    chk("timeout_link", link_up, 0);
    chk("timeout_once", lost_seen, 1);
`ifdef GLITCH_LIMIT_EN
    repeat (10) send_bit(1);
    send_bit(0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("glitch_4_ok", link_up, 1);
    step(0, 0, 0, 1, 0);
    chk("glitch_5_link", link_up, 0);
    chk("glitch_5_err", err_count, 1);
`endif
    rnd = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
      else if (r < 85) repeat ($urandom_range(1, 12)) send_bit(1);
      else if (r < 97) step(1, 1'($urandom_range(0, 1)), 1, 0, 0);
      else repeat (TIMEOUT + 3) step(0, 0, 0, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
